softmax_norm_scheduler: RTL

SOFTMAX_NORM_SCHEDULER -- requirements
Module: softmax_norm_scheduler

---
 rtl/softmax_norm_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/softmax_norm_scheduler.sv
// Softmax normaliser: buffers one vector of exp values, forms a reciprocal of their sum, then scales each element through a shared multiplier.
// Latency 30 cycles from last accept to first output (3 when the sum is zero); o_ready is low outside LOAD; outputs hold while i_ready is low.
module softmax_norm_scheduler #(
    parameter int BIT_WIDTH = 16,
    parameter int VEC_LEN   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic [BIT_WIDTH-1:0] i_data,
    input  logic                 i_last,
    output logic                 o_ready,
    output logic                 o_mulValid,
    output logic [BIT_WIDTH-1:0] o_mulA,
    output logic [BIT_WIDTH-1:0] o_mulB,
    input  logic [BIT_WIDTH-1:0] i_mulData,
    output logic                 o_valid,
    output logic [BIT_WIDTH-1:0] o_data,
    output logic                 o_last,
    input  logic                 i_ready,
    output logic                 o_busy
);
    localparam int SW = BIT_WIDTH + $clog2(VEC_LEN);
    localparam int CW = $clog2(VEC_LEN + 1);
    localparam int AW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int QW = 28;
    localparam logic [CW-1:0] LAST_CNT = CW'(VEC_LEN - 1);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [4:0]    DIV_LAST = 5'd27;

    typedef enum logic [1:0] {LOAD, DIVIDE, SCALE} state_t;

    state_t               state;
    logic [BIT_WIDTH-1:0] buffer [VEC_LEN];
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        idx;
    logic [SW-1:0]        sum;
    logic [SW-1:0]        rem;
    logic [QW-2:0]        quo;
    logic [4:0]           div_cnt;
    logic [BIT_WIDTH-1:0] recip;

    logic                 accept;
    logic                 load_done;
    logic                 mul_fire;
    logic [BIT_WIDTH-1:0] clamped;
    logic [SW:0]          trial;
    logic [SW-1:0]        diff;
    logic                 q_bit;
    logic [QW-1:0]        quo_next;
    logic [BIT_WIDTH-1:0] quo_sat;

    always_comb begin
        accept    = (state == LOAD) && i_valid;
        load_done = accept && (i_last || (cnt == LAST_CNT));
        clamped   = i_data[BIT_WIDTH-1] ? '0 : i_data;
        mul_fire  = (state == SCALE) && (!o_valid || i_ready) && (idx < cnt);
        // Dividend is all ones, so every restoring step shifts in a 1.
        trial     = {rem, 1'b1};
        q_bit     = (trial >= {1'b0, sum});
        diff      = trial[SW-1:0] - sum;
        quo_next  = {quo, q_bit};
        quo_sat   = (|quo_next[QW-1:BIT_WIDTH]) ? '1 : quo_next[BIT_WIDTH-1:0];
    end

    assign o_mulValid = mul_fire;
    assign o_mulA     = (state == SCALE) ? buffer[idx[AW-1:0]] : '0;
    assign o_mulB     = (state == SCALE) ? recip : '0;

    always_ff @(posedge i_clk) begin
        if (accept) begin
            buffer[cnt[AW-1:0]] <= clamped;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= LOAD;
            cnt     <= '0;
            idx     <= '0;
            sum     <= '0;
            rem     <= '0;
            quo     <= '0;
            div_cnt <= '0;
            recip   <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        sum <= sum + SW'(clamped);
                        cnt <= cnt + ONE_C;
                        if (load_done) begin
                            state   <= DIVIDE;
                            o_ready <= 1'b0;
                            o_busy  <= 1'b1;
                            rem     <= '0;
                            quo     <= '0;
                            div_cnt <= '0;
                        end
                    end
                end
                DIVIDE: begin
                    if (sum == '0) begin
                        recip <= '0;
                        state <= SCALE;
                    end else begin
                        rem     <= q_bit ? diff : trial[SW-1:0];
                        quo     <= quo_next[QW-2:0];
                        div_cnt <= div_cnt + 5'd1;
                        if (div_cnt == DIV_LAST) begin
                            recip <= quo_sat;
                            state <= SCALE;
                        end
                    end
                end
                SCALE: begin
                    if (mul_fire) begin
                        o_data  <= i_mulData;
                        o_valid <= 1'b1;
                        o_last  <= (idx == cnt - ONE_C);
                        idx     <= idx + ONE_C;
                    end else if (o_valid && i_ready) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        // Final element consumed: vector done, reopen for loading.
                        if (o_last) begin
                            state   <= LOAD;
                            o_ready <= 1'b1;
                            o_busy  <= 1'b0;
                            cnt     <= '0;
                            idx     <= '0;
                            sum     <= '0;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule
